// File: rtl/if_id_queue_pkg.sv
// Shared constants and the output-register priority decode for the IF/ID queue.
package if_id_queue_pkg;

  // Shared pipeline constants
  localparam logic        Stop       = 1'b1;
  localparam logic        NoStop     = 1'b0;
  localparam logic        Rst_Enable = 1'b1;
  localparam logic [31:0] Zero_Word  = 32'h0;
  localparam logic [31:0] No_Addr    = 32'h0;

  // Default queue depth between fetch and decode
  localparam int Inst_Queue_Depth = 4;

  // Stall vector layout from ctrl
  localparam int STALL_W  = 6;
  localparam int STALL_ID = 1;
  localparam int STALL_EX = 2;

  // What the ID output register does on the next edge
  typedef enum logic [1:0] {
    OUT_HOLD   = 2'd0,
    OUT_BUBBLE = 2'd1,
    OUT_LOAD   = 2'd2
  } out_op_e;

  // Priority: flush, ID-only stall bubble, pop, empty bubble, full hold.
  function automatic out_op_e out_op(input logic flush,
                                     input logic [STALL_W-1:0] stall,
                                     input logic empty);
    out_op_e op;
    op = OUT_HOLD;
    if (flush)
      op = OUT_BUBBLE;
    else if (stall[STALL_ID] == Stop && stall[STALL_EX] == NoStop)
      op = OUT_BUBBLE;
    else if (stall[STALL_ID] == NoStop)
      op = empty ? OUT_BUBBLE : OUT_LOAD;
    return op;
  endfunction

endpackage

// File: rtl/if_id_queue_fetch_fifo.sv
// Generic synchronous FIFO: registered count, clear beats push/pop, no bypass.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_clear,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr_en, w_rd_en;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  assign w_wr_en = i_push && !o_full  && !i_clear;
  assign w_rd_en = i_pop  && !o_empty && !i_clear;

  // Storage write; stale slots are harmless because pointers define validity
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID stage: instruction queue feeding the ID output register,
// with stall bubble/hold and flush handling.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = Inst_Queue_Depth
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid,
  input  logic [ADDR_W-1:0]          if_pc,
  input  logic [DATA_W-1:0]          if_inst,
  output logic                       if_ready,
  input  logic [STALL_W-1:0]         stall,
  input  logic                       flush,
  output logic                       id_valid,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [DATA_W-1:0]          id_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int W = ADDR_W + DATA_W;

  logic          w_push, w_pop, w_full, w_empty;
  logic [W-1:0]  w_head;
  out_op_e       w_op;

  logic              r_id_valid;
  logic [ADDR_W-1:0] r_id_pc;
  logic [DATA_W-1:0] r_id_inst;

  // if_ready depends only on registered occupancy, never on stall/flush
  assign if_ready = !w_full;
  assign w_push   = if_valid && !w_full && !flush;
  assign w_op     = out_op(flush, stall, w_empty);
  assign w_pop    = (w_op == OUT_LOAD);

  fetch_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush),
    .i_din   ({if_pc, if_inst}),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  // ID output register: reset, then load/bubble/hold as decoded
  always_ff @(posedge clk) begin
    if (rst == Rst_Enable) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= ADDR_W'(No_Addr);
      r_id_inst  <= DATA_W'(Zero_Word);
    end else begin
      case (w_op)
        OUT_LOAD: begin
          r_id_valid <= 1'b1;
          r_id_pc    <= w_head[W-1:DATA_W];
          r_id_inst  <= w_head[DATA_W-1:0];
        end
        OUT_BUBBLE: begin
          r_id_valid <= 1'b0;
          r_id_pc    <= '0;
          r_id_inst  <= '0;
        end
        default: begin
          r_id_valid <= r_id_valid;
          r_id_pc    <= r_id_pc;
          r_id_inst  <= r_id_inst;
        end
      endcase
    end
  end

  assign id_valid = r_id_valid;
  assign id_pc    = r_id_pc;
  assign id_inst  = r_id_inst;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios plus random traffic against a queue model.
module tb_if_id_queue;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst, if_valid, flush;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_inst;
  logic [5:0]    stall;
  logic          if_ready, id_valid;
  logic [AW-1:0] id_pc;
  logic [DW-1:0] id_inst;
  logic [2:0]    count;

  if_id_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_ready(if_ready), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_inst(id_inst), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq[$];
  logic        m_vld;
  logic [31:0] m_pc, m_inst;
  bit          m_pushed;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model of one clock edge from the stage's rules, using pre-edge state
  task automatic model_edge();
    m_pushed = 0;
    if (rst) begin
      mq.delete(); m_vld = 0; m_pc = 0; m_inst = 0;
    end else if (flush) begin
      mq.delete(); m_vld = 0; m_pc = 0; m_inst = 0;
    end else begin
      bit take;
      take = if_valid && (mq.size() < D);
      if (stall[1] && !stall[2]) begin
        m_vld = 0; m_pc = 0; m_inst = 0;
      end else if (!stall[1]) begin
        if (mq.size() > 0) begin
          ent_t e;
          e = mq.pop_front();
          m_vld = 1; m_pc = e.pc; m_inst = e.inst;
        end else begin
          m_vld = 0; m_pc = 0; m_inst = 0;
        end
      end
      if (take) begin
        mq.push_back('{pc: if_pc, inst: if_inst});
        m_pushed = 1;
      end
    end
  endtask

  // One cycle: drive at negedge, model at posedge, compare at next negedge
  task automatic cyc(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                     input logic [5:0] st, input bit fl, input bit r);
    if_valid = v; if_pc = pc; if_inst = inst; stall = st; flush = fl; rst = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("count",    64'(count),    64'(mq.size()));
    chk("if_ready", 64'(if_ready), 64'(mq.size() < D));
    chk("id_valid", 64'(id_valid), 64'(m_vld));
    chk("id_pc",    64'(id_pc),    64'(m_pc));
    chk("id_inst",  64'(id_inst),  64'(m_inst));
  endtask

  localparam logic [5:0] HOLD = 6'b000110;
  localparam logic [5:0] BUB  = 6'b000010;
  localparam logic [5:0] RUN  = 6'b000000;

  initial begin
    int k;
    rst = 1; if_valid = 0; if_pc = 0; if_inst = 0; stall = 0; flush = 0;
    @(negedge clk);
    cyc(0, 0, 0, RUN, 0, 1);
    cyc(0, 0, 0, RUN, 0, 1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(if_ready), 64'd1);
    chk("rst_valid", 64'(id_valid), 64'd0);

    // Streaming: 2-cycle latency, 1/cycle throughput
    cyc(1, 32'h100, 32'hA, RUN, 0, 0);
    chk("s0_valid", 64'(id_valid), 64'd0);
    cyc(1, 32'h104, 32'hB, RUN, 0, 0);
    chk("s1_pc", 64'(id_pc), 64'h100);
    chk("s1_inst", 64'(id_inst), 64'hA);
    chk("s1_count", 64'(count), 64'd1);
    cyc(1, 32'h108, 32'hC, RUN, 0, 0);
    chk("s2_pc", 64'(id_pc), 64'h104);
    cyc(0, 0, 0, RUN, 0, 0);
    chk("s3_pc", 64'(id_pc), 64'h108);
    chk("s3_valid", 64'(id_valid), 64'd1);
    cyc(0, 0, 0, RUN, 0, 0);
    chk("s4_valid", 64'(id_valid), 64'd0);

    // Decode stall fills the queue; IF holds its data until accepted
    k = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 32'h300 + 32'(4*k), 32'h30 + 32'(k), HOLD, 0, 0);
      if (m_pushed) k++;
    end
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_ready", 64'(if_ready), 64'd0);
    chk("fill_valid", 64'(id_valid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 32'h300 + 32'(4*k), 32'h30 + 32'(k), RUN, 0, 0);
      if (m_pushed) k++;
      chk("drain_pc", 64'(id_pc), 64'h300 + 64'(4*i));
    end
    repeat (6) cyc(0, 0, 0, RUN, 0, 0);

    // Bubble with one entry queued
    cyc(1, 32'h200, 32'h20, HOLD, 0, 0);
    cyc(0, 0, 0, BUB, 0, 0);
    chk("bub_valid", 64'(id_valid), 64'd0);
    chk("bub_pc", 64'(id_pc), 64'd0);
    chk("bub_count", 64'(count), 64'd1);
    cyc(0, 0, 0, RUN, 0, 0);
    chk("bub_next_pc", 64'(id_pc), 64'h200);

    // Flush with queued entries and a concurrent push
    for (int i = 0; i < 3; i++) cyc(1, 32'h400 + 32'(4*i), 32'h40 + 32'(i), HOLD, 0, 0);
    cyc(1, 32'h40C, 32'h43, HOLD, 1, 0);
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_valid", 64'(id_valid), 64'd0);
    cyc(1, 32'h500, 32'h50, RUN, 0, 0);
    chk("fl_next_count", 64'(count), 64'd1);
    cyc(0, 0, 0, RUN, 0, 0);
    chk("fl_next_pc", 64'(id_pc), 64'h500);

    // Pointer wrap at steady occupancy 2
    cyc(1, 32'h600, 32'h60, HOLD, 0, 0);
    cyc(1, 32'h604, 32'h61, HOLD, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 32'h608 + 32'(4*i), 32'h62 + 32'(i), RUN, 0, 0);
      chk("wrap_pc", 64'(id_pc), 64'h600 + 64'(4*i));
      chk("wrap_count", 64'(count), 64'd2);
    end
    repeat (3) cyc(0, 0, 0, RUN, 0, 0);

    // Reset while full and stalled
    for (int i = 0; i < 4; i++) cyc(1, 32'h700 + 32'(4*i), 32'h70, HOLD, 0, 0);
    chk("rf_count", 64'(count), 64'd4);
    cyc(1, 32'h710, 32'h74, HOLD, 1, 1);
    chk("rr_count", 64'(count), 64'd0);
    chk("rr_ready", 64'(if_ready), 64'd1);
    chk("rr_valid", 64'(id_valid), 64'd0);
    chk("rr_pc", 64'(id_pc), 64'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 4) != 0, $urandom, $urandom, 6'($urandom),
          ($urandom % 25) == 0, ($urandom % 150) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised fetch-to-decode pipeline stage with a DEPTH-entry instruction queue between IF and the ID output register. It absorbs fetched instructions while decode is stalled, honours the 6-bit `stall` vector from ctrl, and supports a synchronous flush for branch and exception redirect. It replaces the single-register IF/ID stage. The stall and bubble semantics are unchanged, with decoupling depth added.

## Interface
Parameters:
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction word width
- DEPTH, 4, queue entries; power of two, ≥2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high (`Rst_Enable` = 1)
- if_valid  in  1  IF presents a fetched instruction this cycle
- if_pc  in  ADDR_W  address of the fetched instruction
- if_inst  in  DATA_W  fetched instruction word
- if_ready  out  1  queue can accept; equals (count != DEPTH)
- stall  in  6  ctrl stall vector; bit1 = ID-input stall, bit2 = EX-input stall
- flush  in  1  discard all queued and output state
- id_valid  out  1  id_pc/id_inst hold a real instruction (0 = bubble)
- id_pc  out  ADDR_W  address to decode
- id_inst  out  DATA_W  instruction to decode
- count  out  $clog2(DEPTH+1)  current queue occupancy

## Operation
- Reset (rst=1 at edge): count=0, rd/wr pointers=0, id_valid=0, id_pc=`No_Addr`, id_inst=`Zero_Word`. if_ready=1 from the next cycle.
- Push: if_valid && if_ready && !flush && !rst writes {if_pc, if_inst} at wr_ptr. wr_ptr increments modulo DEPTH.
- Output register update priority per edge, highest first:
  1. rst.
  2. flush: id_valid=0, id_pc=id_inst=0. Queue is emptied, count=0, pointers=0. A concurrent push is dropped.
  3. stall[1]=`Stop` && stall[2]=`NoStop`: a bubble is inserted (id_valid=0, id_pc=id_inst=0). No pop.
  4. stall[1]=`NoStop` && count≠0: pop head into output register with id_valid=1. rd_ptr increments modulo DEPTH.
  5. stall[1]=`NoStop` && count=0: bubble (id_valid=0, zeros).
  6. Otherwise (stall[1]=`Stop` && stall[2]=`Stop`): output register holds.
- Simultaneous push and pop: both occur, and count is unchanged. A push when full is impossible because if_ready=0. IF must hold its data until if_ready=1.
- No bypass: an entry pushed at edge k is poppable no earlier than edge k+1.
- count = pushes − pops, saturating is never needed. Pointers are log2(DEPTH) bits and wrap naturally.

## Timing
- Minimum latency: if_valid sampled at edge k, visible on id_* after edge k+1, so 2 cycles from fetch to decode.
- Steady-state throughput: 1 instruction/cycle with no stall.
- if_ready and count are registered-state functions. if_ready has no combinational path from stall or flush.
- flush asserted at edge k: id_valid=0 and count=0 after edge k. Instructions presented at edge k+1 are accepted normally.
- rst mid-stream overrides flush, stall and push in the same edge.

## Structure
- Constants `Stop`, `NoStop`, `Rst_Enable`, `Zero_Word`, `No_Addr` come from the shared define.v. Add `Inst_Queue_Depth` (4) there as the default DEPTH.
- Sub-module `fetch_fifo`: a generic synchronous FIFO (WIDTH=ADDR_W+DATA_W, DEPTH) with push, pop, clear, full, empty and count.
- if_id_queue contains only the output register and the stall/flush priority logic.

## Test plan
- Reset then stream: pc 0x100,0x104,0x108 with inst 0xA,0xB,0xC on consecutive cycles, stall=0 → id_pc 0x100/0x104/0x108 with id_valid=1 on edges 2,3,4 and count ≤1.
- Decode stall fill: stall=6'b000110 for 6 cycles while IF pushes every cycle → id_* held, count reaches 4, if_ready=0. The 5th instruction is not taken until release, then 4 queued entries drain in order.
- Bubble: stall=6'b000010 for 1 cycle with queue holding 0x200 → id_valid=0, id_pc=0 that cycle. 0x200 appears on the following edge.
- Flush with 3 queued entries plus concurrent push → after the edge count=0, id_valid=0, and the pushed entry is never output. The next push appears 2 cycles later.
- Wrap-around: 10 push/pop pairs at DEPTH=4 with occupancy held at 2 → output order matches input exactly.
- rst asserted while full and stalled → next cycle all outputs at reset values, count=0, if_ready=1.
